// File: rtl/signed_acc_pkg.sv
// Shared types and helpers for the signed saturating accumulator.
// State and mode enums plus signed range limits for a given width.
package signed_acc_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_t;

    // Bit pattern of the largest signed value of width w (low w bits).
    function automatic logic [63:0] smax(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Bit pattern of the most negative signed value of width w (low w bits).
    function automatic logic [63:0] smin(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/signed_add_sat.sv
// Combinational W-bit signed adder with overflow flag.
// Optionally clamps the result to the signed range on overflow.
module signed_add_sat
    import signed_acc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sat,
    output logic [W-1:0] res,
    output logic         ovf
);

    localparam logic [W-1:0] MAXV = W'(smax(W));
    localparam logic [W-1:0] MINV = W'(smin(W));

    logic [W-1:0] w_sum;

    assign w_sum = a + b;
    assign ovf   = (a[W-1] == b[W-1]) && (w_sum[W-1] != a[W-1]);

    // Pick modular sum, or the clamp value in the direction of the overflow.
    always_comb begin
        res = w_sum;
        if (ovf && sat) begin
            res = a[W-1] ? MINV : MAXV;
        end
    end

endmodule

// File: rtl/signed_acc_sat.sv
// Two-stage signed batch accumulator with wrap/saturate modes.
// Stage 1 registers the operand; stage 2 runs the batch FSM.
module signed_acc_sat
    import signed_acc_pkg::*;
#(
    parameter int W   = 8,
    parameter int LEN = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         mode,
    output logic [W-1:0] acc,
    output logic         ovf,
    output logic         ovf_sticky,
    output logic [W-1:0] sum,
    output logic         sum_valid,
    output logic         sum_ovf
);

    localparam int            CW   = $clog2(LEN + 1);
    localparam logic [CW-1:0] LENC = CW'(LEN);

    logic          r_s1_valid;
    logic [W-1:0]  r_s1_data;
    mode_t         r_s1_mode;

    state_t        r_state;
    logic [W-1:0]  r_acc;
    logic [CW-1:0] r_cnt;
    logic          r_ovf;
    logic          r_sticky;
    logic [W-1:0]  r_sum;
    logic          r_sum_valid;
    logic          r_sum_ovf;

    state_t        w_state;
    logic [W-1:0]  w_acc;
    logic [CW-1:0] w_cnt;
    logic          w_ovf;
    logic          w_sticky;
    logic [W-1:0]  w_sum;
    logic          w_sum_valid;
    logic          w_sum_ovf;

    logic [W-1:0]  w_base;
    logic          w_st_base;
    logic [CW-1:0] w_cnt_inc;
    logic [W-1:0]  w_add_res;
    logic          w_add_ovf;
    logic          w_sat;

    assign w_sat = (r_s1_mode == MODE_SAT);

    signed_add_sat #(
        .W(W)
    ) u_add (
        .a  (w_base),
        .b  (r_s1_data),
        .sat(w_sat),
        .res(w_add_res),
        .ovf(w_add_ovf)
    );

    // Stage 1: capture the operand; clear drops it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_mode  <= MODE_WRAP;
        end else if (clear) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= in_valid;
            r_s1_data  <= in_data;
            r_s1_mode  <= mode_t'(mode);
        end
    end

    // Stage 2: FSM next state, accumulator and batch result.
    always_comb begin
        w_state     = r_state;
        w_acc       = r_acc;
        w_cnt       = r_cnt;
        w_ovf       = 1'b0;
        w_sticky    = r_sticky;
        w_sum       = r_sum;
        w_sum_valid = 1'b0;
        w_sum_ovf   = r_sum_ovf;
        w_base      = '0;
        w_st_base   = 1'b0;
        w_cnt_inc   = r_cnt + CW'(1);
        unique case (r_state)
            ST_IDLE: begin
                w_base    = '0;
                w_st_base = 1'b0;
                w_cnt_inc = CW'(1);
            end
            ST_ACCUM: begin
                w_base    = r_acc;
                w_st_base = r_sticky;
            end
        endcase
        if (clear) begin
            w_state  = ST_IDLE;
            w_acc    = '0;
            w_cnt    = '0;
            w_sticky = 1'b0;
        end else if (r_s1_valid) begin
            w_acc    = w_add_res;
            w_ovf    = w_add_ovf;
            w_sticky = w_st_base | w_add_ovf;
            if (w_cnt_inc == LENC) begin
                w_state     = ST_IDLE;
                w_cnt       = '0;
                w_sum       = w_add_res;
                w_sum_ovf   = w_st_base | w_add_ovf;
                w_sum_valid = 1'b1;
            end else begin
                w_state = ST_ACCUM;
                w_cnt   = w_cnt_inc;
            end
        end
    end

    // Stage 2 state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_sticky    <= 1'b0;
            r_sum       <= '0;
            r_sum_valid <= 1'b0;
            r_sum_ovf   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_acc       <= w_acc;
            r_cnt       <= w_cnt;
            r_ovf       <= w_ovf;
            r_sticky    <= w_sticky;
            r_sum       <= w_sum;
            r_sum_valid <= w_sum_valid;
            r_sum_ovf   <= w_sum_ovf;
        end
    end

    assign acc        = r_acc;
    assign ovf        = r_ovf;
    assign ovf_sticky = r_sticky;
    assign sum        = r_sum;
    assign sum_valid  = r_sum_valid;
    assign sum_ovf    = r_sum_ovf;

endmodule

// File: tb/tb_signed_acc_sat.sv
// Bench for signed_acc_sat: three instances (W4/LEN4, W4/LEN1, W8/LEN4)
// against an integer-arithmetic batch model, plus directed vectors.
module tb_signed_acc_sat;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic [7:0] d8;
    logic       mode;

    logic [3:0] acc_a, sum_a, acc_b, sum_b;
    logic [7:0] acc_c, sum_c;
    logic       ov_a, st_a, sv_a, so_a;
    logic       ov_b, st_b, sv_b, so_b;
    logic       ov_c, st_c, sv_c, so_c;

    always #5 clk = ~clk;

    signed_acc_sat #(.W(4), .LEN(4)) dut_a (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .in_data(d8[3:0]), .mode(mode), .acc(acc_a), .ovf(ov_a),
        .ovf_sticky(st_a), .sum(sum_a), .sum_valid(sv_a), .sum_ovf(so_a)
    );

    signed_acc_sat #(.W(4), .LEN(1)) dut_b (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .in_data(d8[3:0]), .mode(mode), .acc(acc_b), .ovf(ov_b),
        .ovf_sticky(st_b), .sum(sum_b), .sum_valid(sv_b), .sum_ovf(so_b)
    );

    signed_acc_sat #(.W(8), .LEN(4)) dut_c (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .in_data(d8), .mode(mode), .acc(acc_c), .ovf(ov_c),
        .ovf_sticky(st_c), .sum(sum_c), .sum_valid(sv_c), .sum_ovf(so_c)
    );

    int total = 0;
    int bad   = 0;

    int MW[3] = '{4, 4, 8};
    int ML[3] = '{4, 1, 4};
    int m_acc[3], m_cnt[3], m_sum[3], m_px[3];
    bit m_ovf[3], m_st[3], m_sv[3], m_so[3], m_pv[3], m_pm[3];

    int cyc = 0;
    int nsv_a = 0;
    int nsv_b = 0;
    bit seen_ovf_a = 0;
    int sv_cyc[$];

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int sx(input logic [7:0] v, input int w);
        int u;
        u = int'(v) & ((1 << w) - 1);
        return (u >= (1 << (w - 1))) ? u - (1 << w) : u;
    endfunction

    task automatic model_step();
        int s, hi, lo, r, base, x;
        bit o, stb;
        for (int i = 0; i < 3; i++) begin
            x = sx(d8, MW[i]);
            if (rst) begin
                m_acc[i] = 0; m_cnt[i] = 0; m_sum[i] = 0;
                m_ovf[i] = 0; m_st[i] = 0; m_sv[i] = 0;
                m_so[i] = 0; m_pv[i] = 0;
            end else if (clear) begin
                m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
                m_st[i] = 0; m_sv[i] = 0; m_pv[i] = 0;
            end else begin
                m_ovf[i] = 0;
                m_sv[i]  = 0;
                if (m_pv[i]) begin
                    hi   = (1 << (MW[i] - 1)) - 1;
                    lo   = -(1 << (MW[i] - 1));
                    base = (m_cnt[i] == 0) ? 0 : m_acc[i];
                    stb  = (m_cnt[i] == 0) ? 1'b0 : m_st[i];
                    s    = base + m_px[i];
                    o    = 0;
                    r    = s;
                    if (s > hi) begin
                        o = 1;
                        r = m_pm[i] ? hi : s - (1 << MW[i]);
                    end else if (s < lo) begin
                        o = 1;
                        r = m_pm[i] ? lo : s + (1 << MW[i]);
                    end
                    m_acc[i] = r;
                    m_ovf[i] = o;
                    m_st[i]  = stb | o;
                    m_cnt[i] = m_cnt[i] + 1;
                    if (m_cnt[i] == ML[i]) begin
                        m_sum[i] = r;
                        m_so[i]  = m_st[i];
                        m_sv[i]  = 1;
                        m_cnt[i] = 0;
                    end
                end
                m_pv[i] = in_valid;
                m_px[i] = x;
                m_pm[i] = mode;
            end
        end
    endtask

    task automatic chk_inst(input int i, input int a, input bit o,
                            input bit s, input int su, input bit v,
                            input bit so);
        chk($sformatf("i%0d.acc", i), a, m_acc[i]);
        chk($sformatf("i%0d.ovf", i), int'(o), int'(m_ovf[i]));
        chk($sformatf("i%0d.sticky", i), int'(s), int'(m_st[i]));
        chk($sformatf("i%0d.sum", i), su, m_sum[i]);
        chk($sformatf("i%0d.sv", i), int'(v), int'(m_sv[i]));
        chk($sformatf("i%0d.so", i), int'(so), int'(m_so[i]));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        if (sv_a) begin
            nsv_a++;
            sv_cyc.push_back(cyc);
        end
        if (sv_b) nsv_b++;
        if (ov_a) seen_ovf_a = 1;
        chk_inst(0, sx({4'b0, acc_a}, 4), ov_a, st_a,
                 sx({4'b0, sum_a}, 4), sv_a, so_a);
        chk_inst(1, sx({4'b0, acc_b}, 4), ov_b, st_b,
                 sx({4'b0, sum_b}, 4), sv_b, so_b);
        chk_inst(2, sx(acc_c, 8), ov_c, st_c, sx(sum_c, 8), sv_c, so_c);
    endtask

    task automatic op(input int v, input bit m);
        in_valid = 1; d8 = 8'(v); mode = m; clear = 0; rst = 0;
        step();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            in_valid = 0; d8 = 8'h00; clear = 0; rst = 0;
            step();
        end
    endtask

    task automatic do_clear();
        in_valid = 0; clear = 1; rst = 0;
        step();
        clear = 0;
    endtask

    initial begin
        rst = 1; clear = 0; in_valid = 0; d8 = 0; mode = 0;
        step();
        step();
        chk("rst.acc", sx({4'b0, acc_a}, 4), 0);
        chk("rst.sum", sx({4'b0, sum_a}, 4), 0);

        op(1, 0); op(2, 0);
        chk("b1.acc1", sx({4'b0, acc_a}, 4), 1);
        op(-1, 0);
        chk("b1.acc3", sx({4'b0, acc_a}, 4), 3);
        op(3, 0);
        chk("b1.acc2", sx({4'b0, acc_a}, 4), 2);
        idle(1);
        chk("b1.acc5", sx({4'b0, acc_a}, 4), 5);
        chk("b1.sum", sx({4'b0, sum_a}, 4), 5);
        chk("b1.sv", int'(sv_a), 1);
        chk("b1.so", int'(so_a), 0);
        idle(2);
        chk("b1.nsv", nsv_a, 1);

        seen_ovf_a = 0;
        op(4, 0); op(7, 0); idle(2);
        chk("wrap.acc", sx({4'b0, acc_a}, 4), -5);
        chk("wrap.ovf", int'(seen_ovf_a), 1);
        do_clear();
        seen_ovf_a = 0;
        op(4, 1); op(7, 1); idle(2);
        chk("sat.acc", sx({4'b0, acc_a}, 4), 7);
        chk("sat.ovf", int'(seen_ovf_a), 1);
        do_clear();

        op(-4, 1); op(-7, 1);
        chk("neg.acc0", sx({4'b0, acc_a}, 4), -4);
        op(3, 1);
        chk("neg.acc1", sx({4'b0, acc_a}, 4), -8);
        op(1, 1);
        chk("neg.acc2", sx({4'b0, acc_a}, 4), -5);
        idle(1);
        chk("neg.acc3", sx({4'b0, acc_a}, 4), -4);
        chk("neg.sum", sx({4'b0, sum_a}, 4), -4);
        chk("neg.so", int'(so_a), 1);
        idle(2);

        nsv_a = 0;
        sv_cyc.delete();
        for (int k = 0; k < 8; k++) op(1, 0);
        idle(2);
        chk("b2b.nsv", nsv_a, 2);
        if (sv_cyc.size() == 2)
            chk("b2b.gap", sv_cyc[1] - sv_cyc[0], 4);
        else
            chk("b2b.pulses", sv_cyc.size(), 2);
        chk("b2b.sum", sx({4'b0, sum_a}, 4), 4);

        nsv_a = 0;
        op(1, 0); op(1, 0);
        in_valid = 1; d8 = 8'd1; clear = 1;
        step();
        clear = 0;
        idle(2);
        chk("clr.acc", sx({4'b0, acc_a}, 4), 0);
        chk("clr.nsv", nsv_a, 0);
        chk("clr.sum", sx({4'b0, sum_a}, 4), 4);
        op(1, 0); op(2, 0); op(1, 0); op(2, 0); idle(2);
        chk("clr.nsv2", nsv_a, 1);
        chk("clr.sum2", sx({4'b0, sum_a}, 4), 6);

        op(1, 0); op(1, 0);
        in_valid = 0; rst = 1;
        step();
        rst = 0;
        chk("mrst.acc", sx({4'b0, acc_a}, 4), 0);
        chk("mrst.sum", sx({4'b0, sum_a}, 4), 0);
        chk("mrst.sv", int'(sv_a), 0);
        op(1, 0); op(1, 0); op(1, 0); op(2, 0); idle(2);
        chk("mrst.sum2", sx({4'b0, sum_a}, 4), 5);
        do_clear();

        nsv_b = 0;
        op(-8, 0); op(-8, 0); op(-8, 0); idle(2);
        chk("len1.nsv", nsv_b, 3);
        chk("len1.sum", sx({4'b0, sum_b}, 4), -8);
        do_clear();

        for (int k = 0; k < 400; k++) begin
            rst      = ($urandom_range(0, 99) == 0);
            clear    = ($urandom_range(0, 24) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            d8       = 8'($urandom);
            mode     = 1'($urandom);
            step();
        end
        rst = 0; clear = 0;
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/signed_acc_sat.md
SIGNED_ACC_SAT -- requirements
Module: signed_acc_sat

Interface
REQ-001 Parameter W, default 8: two's-complement operand, accumulator and result width; W >= 2.
REQ-002 Parameter LEN, default 4: operands per batch; LEN >= 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 clear  input  1  synchronous soft clear of batch state.
REQ-006 in_valid  input  1  in_data carries an operand this cycle; always accepted, no back-pressure.
REQ-007 in_data  input  W  signed operand.
REQ-008 mode  input  1  0 = wrap, 1 = saturate; sampled with the operand.
REQ-009 acc  output  W  running signed accumulator.
REQ-010 ovf  output  1  one-cycle pulse: the last accumulate step overflowed.
REQ-011 ovf_sticky  output  1  some step of the current batch overflowed.
REQ-012 sum  output  W  final batch result, held until the next batch completes.
REQ-013 sum_valid  output  1  one-cycle pulse when sum updates.
REQ-014 sum_ovf  output  1  ovf_sticky value of the batch held in sum.

Function
REQ-015 Stage 1 SHALL register in_valid, in_data and mode. Stage 2 SHALL update the accumulator. An operand presented at edge t appears in acc after edge t+2.
REQ-016 Overflow SHALL be asserted when the operand and acc have equal sign bits and the W-bit sum has a different sign bit.
REQ-017 In wrap mode, acc SHALL take the W-bit modular sum.
REQ-018 In saturate mode, positive overflow SHALL give 2^(W-1)-1 and negative overflow SHALL give -2^(W-1).
REQ-019 In both modes, ovf SHALL pulse on overflow.
REQ-020 The FSM SHALL have two states: IDLE (count=0) and ACCUM.
REQ-021 In IDLE, a stage-2 operand SHALL load acc = 0 + operand, set count=1 and move to ACCUM; if LEN=1 it SHALL complete immediately.
REQ-022 In ACCUM, each stage-2 operand SHALL add into acc and increment count.
REQ-023 When count reaches LEN, the FSM SHALL latch sum = new acc and sum_ovf = new sticky, pulse sum_valid, and return to IDLE.
REQ-024 acc and ovf_sticky SHALL hold their values in IDLE after a completion.
REQ-025 The next operand after a completion SHALL start from zero, and ovf_sticky SHALL restart with that operand's ovf.
REQ-026 Back-to-back operands across a batch boundary SHALL lose no cycle.
REQ-027 Cycles with in_valid=0 SHALL leave all state unchanged, and ovf and sum_valid SHALL be 0.
REQ-028 clear SHALL zero acc, count, ovf, ovf_sticky and the stage-1 valid, and SHALL force IDLE.
REQ-029 clear SHALL leave sum and sum_ovf unchanged.
REQ-030 When clear coincides with in_valid, clear SHALL win and the operand SHALL be dropped; an operand already in stage 2 SHALL also be discarded.
REQ-031 The counter SHALL be $clog2(LEN+1) bits wide and SHALL never wrap past LEN.

Reset
REQ-032 On rst, all registers SHALL be zeroed: acc=0, ovf=0, ovf_sticky=0, sum=0, sum_valid=0, sum_ovf=0, stage-1 valid=0, count=0, state=IDLE.
REQ-033 rst SHALL take priority over clear and in_valid.
REQ-034 rst mid-batch SHALL abandon the batch without a sum_valid pulse.

Structure
REQ-035 Package signed_acc_pkg SHALL hold: the FSM state enum, the mode enum (MODE_WRAP, MODE_SAT), and functions returning the max and min signed value for a width.
REQ-036 One combinational sub-module, signed_add_sat, SHALL be used.
REQ-037 signed_add_sat SHALL be parametrised by W, with inputs a, b, sat and outputs res, ovf, and SHALL hold the overflow and saturation logic.

Verification (W=4, LEN=4 unless noted)
REQ-038 Operands 1,2,-1,3 in wrap mode on consecutive cycles -> acc 1,3,2,5 at edges t+2..t+5; sum=5 with one sum_valid pulse; sum_ovf=0.
REQ-039 Operands 4,7 in wrap mode -> acc=-5 (4'b1011) and ovf pulse on the second step; the same operands in saturate mode -> acc=7, ovf pulse.
REQ-040 Operands -4,-7 in saturate mode, then 3,1 -> acc -4,-8,-5,-4; sum=-4; sum_ovf=1.
REQ-041 Eight back-to-back operands of 1 -> two sum_valid pulses, 4 cycles apart, each with sum=4; acc restarts at 1 with no gap.
REQ-042 clear asserted with the third operand of a batch -> that operand is dropped, acc=0, no sum_valid, sum retains its prior value; the next 4 operands form a complete batch.
REQ-043 rst mid-batch (after 2 operands) -> all outputs 0 on the next cycle; the following 4 operands produce a correct sum.
REQ-044 With LEN=1, operand -8 in wrap mode -> sum=-8 and sum_valid pulse every operand; every output matches a reference model of REQ-016 to REQ-019 over random stimulus for W=4 and W=8.
